multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore main-control FSM sequencing the multicycle RV32I datapath: PC, instruction/data memory, register file, ALU.
- Generates the 2-bit ALUOp consumed by the ALU decoder, which produces ALUControl from ALUOp, funct3, op[5] and funct7[5].
- Also generates mux selects, write enables, ImmSrc, an illegal-opcode flag and a retired-instruction counter.
- Supports lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- op  input  7  opcode field of the instruction register
- zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction/OldPC register enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1 data
- ALUSrcB  output  2  ALU operand B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- illegal  output  1  one-cycle pulse in Decode when op is unsupported
- state  output  4  current state encoding (debug)
- instret  output  CNT_W  retired-instruction count

Behaviour:
- State encoding (4 bits):
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10
  - Codes 11–15 are unreachable; if entered, next state = FETCH and all controls = 0.
- Reset: asynchronous, active-high. state <= FETCH and instret <= 0 immediately. Outputs show FETCH values while reset is high. Reset mid-instruction abandons that instruction with no count.
- Transitions, one per rising edge:
  - FETCH -> DECODE
  - DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH
  - MEMADR: op 0000011 -> MEMREAD, else -> MEMWRITE
  - MEMREAD -> MEMWB
  - EXECR, EXECI, JAL -> ALUWB
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH
- Output values per state. Any signal not listed is 0; no X values are driven.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrite=1
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero
- PCWrite is a combinational function of state and zero (PCUpdate | Branch&zero). It is the only output depending on a non-state input other than op.
- ImmSrc is combinational on op in every state:
  - 0000011, 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- illegal = 1 only while state == DECODE and op is unsupported.
- instret:
  - Increments by 1 on the edge leaving MEMWB, MEMWRITE, ALUWB or BEQ. BEQ counts whether taken or not.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes and abandoned instructions do not count.
- Cycle counts per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.

Test Plan:
- Reset asserted mid-MEMREAD, async between edges -> state=0 and instret=0 before the next edge. Outputs IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0000011 (lw) from FETCH -> states 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. ImmSrc=00. instret +1 after 5 cycles.
- op=0100011 (sw) -> states 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1. ImmSrc=01. RegWrite never 1.
- op=1100011 with zero=1, then with zero=0 -> states 0,1,10,0 each time. PCWrite=1 in BEQ only for zero=1. ALUOp=01. instret +2 total.
- op=0110011, then 0010011, then 1101111 -> ALUOp=10 in states 6 and 8. State 9 has PCWrite=1, ALUSrcA=01. Each passes through ALUWB (RegWrite=1). instret +3.
- op=1110011 (unsupported) -> states 0,1,0 with illegal=1 for exactly the DECODE cycle and instret unchanged. With CNT_W=4, 16 retired R-types -> instret wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore main-control FSM for a multicycle RV32I datapath
//               (lw, sw, R-type, I-type ALU, beq, jal). Drives PC/IR/memory/
//               register-file enables, mux selects, ALUOp for the ALU decoder,
//               ImmSrc, an illegal-opcode flag and a retired-instruction
//               counter.
// Ports       : clk, reset            - clock, async active-high reset
//               op, zero              - opcode field, ALU zero flag
//               PCWrite..ALUOp        - datapath controls
//               ImmSrc                - immediate format (I/S/B/J)
//               illegal               - unsupported opcode seen in DECODE
//               state                 - current state (debug)
//               instret               - retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;
  logic   w_supported;
  logic   w_retire;
  logic   w_pc_update;
  logic   w_branch;

  // --------------------------------------------------------------------------
  // Opcode classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_supported = 1'b0;
    case (op)
      c_OP_LW, c_OP_SW, c_OP_R, c_OP_I, c_OP_JAL, c_OP_BEQ: w_supported = 1'b1;
      default:                                              w_supported = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Codes 11-15 fall to the default arm and recover to FETCH.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_R:           w_next = S_EXECR;
          c_OP_I:           w_next = S_EXECI;
          c_OP_JAL:         w_next = S_JAL;
          c_OP_BEQ:         w_next = S_BEQ;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      w_next = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ:      w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // The last state of every instruction is where it retires; BEQ retires
  // whether or not the branch is taken.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: w_retire = 1'b1;
      default:                             w_retire = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        instret <= instret + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Moore output decode. Decoded straight from the state register so that the
  // FETCH values appear as soon as reset forces the state, and unreachable
  // codes drive all controls low.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target OldPC + imm for a possible beq
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_JAL: begin
        // PC <= ALUOut (target from DECODE); ALU forms OldPC + 4 for rd
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = w_pc_update | (w_branch & zero);

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      c_OP_SW:  ImmSrc = 2'b01;
      c_OP_BEQ: ImmSrc = 2'b10;
      c_OP_JAL: ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign illegal = (r_state == S_DECODE) & ~w_supported;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller,
//               instantiated with a 4-bit counter so that wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [6:0]       op;
  logic             zero;
  logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  int               n_vec;
  int               n_miss;
  logic [CNT_W-1:0] exp_cnt;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal),
    .state     (state),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [12:0] exp_ctl(input logic [3:0] st, input logic z);
    case (st)
      4'd0:    return 13'b1_0_0_1_0_10_00_10_00;
      4'd1:    return 13'b0_0_0_0_0_00_01_01_00;
      4'd2:    return 13'b0_0_0_0_0_00_10_01_00;
      4'd3:    return 13'b0_1_0_0_0_00_00_00_00;
      4'd4:    return 13'b0_0_0_0_1_01_00_00_00;
      4'd5:    return 13'b0_1_1_0_0_00_00_00_00;
      4'd6:    return 13'b0_0_0_0_0_00_10_00_10;
      4'd7:    return 13'b0_0_0_0_1_00_00_00_00;
      4'd8:    return 13'b0_0_0_0_0_00_10_01_10;
      4'd9:    return 13'b1_0_0_0_0_00_01_10_00;
      4'd10:   return {z, 12'b0_0_0_0_00_10_00_01};
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [12:0] obs_ctl();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  // Runs one instruction from FETCH. seq holds the expected state per cycle,
  // first state in the low nibble. Called just after a falling edge.
  task automatic run_instr(input string tag, input logic [6:0] opc, input logic z,
                           input int n, input logic [23:0] seq,
                           input logic [1:0] imm_exp, input logic is_illegal);
    logic [3:0] es;
    op   = opc;
    zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      es = seq[4*i +: 4];
      chk({tag, "_state"},   {28'd0, state},    {28'd0, es});
      chk({tag, "_ctl"},     {19'd0, obs_ctl()}, {19'd0, exp_ctl(es, z)});
      chk({tag, "_immsrc"},  {30'd0, ImmSrc},   {30'd0, imm_exp});
      chk({tag, "_illegal"}, {31'd0, illegal},
          {31'd0, (is_illegal && es == 4'd1)});
      @(negedge clk);
      #1;
    end
    if (!is_illegal) exp_cnt = exp_cnt + 1'b1;
    chk({tag, "_end_state"}, {28'd0, state},   32'd0);
    chk({tag, "_instret"},   {28'd0, instret}, {28'd0, exp_cnt});
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_cnt = '0;
    reset   = 1'b1;
    op      = 7'd0;
    zero    = 1'b0;

    #3;
    chk("rst_state",   {28'd0, state},    32'd0);
    chk("rst_instret", {28'd0, instret},  32'd0);
    chk("rst_ctl",     {19'd0, obs_ctl()}, {19'd0, exp_ctl(4'd0, 1'b0)});

    @(negedge clk);
    reset = 1'b0;

    // lw, sw, beq taken / not taken
    run_instr("lw",      7'b0000011, 1'b0, 5, 24'h043210, 2'b00, 1'b0);
    run_instr("sw",      7'b0100011, 1'b0, 4, 24'h005210, 2'b01, 1'b0);
    run_instr("beq_t",   7'b1100011, 1'b1, 3, 24'h000A10, 2'b10, 1'b0);
    run_instr("beq_nt",  7'b1100011, 1'b0, 3, 24'h000A10, 2'b10, 1'b0);
    // R, I, jal
    run_instr("rtype",   7'b0110011, 1'b0, 4, 24'h007610, 2'b00, 1'b0);
    run_instr("itype",   7'b0010011, 1'b0, 4, 24'h007810, 2'b00, 1'b0);
    run_instr("jal",     7'b1101111, 1'b1, 4, 24'h007910, 2'b11, 1'b0);
    // unsupported opcode: 2 cycles, no count
    run_instr("illegal", 7'b1110011, 1'b0, 2, 24'h000010, 2'b00, 1'b1);

    // Asynchronous reset in the middle of MEMREAD
    op   = 7'b0000011;
    zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_memread", {28'd0, state}, 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_state",   {28'd0, state},    32'd0);
    chk("async_instret", {28'd0, instret},  32'd0);
    chk("async_ctl",     {19'd0, obs_ctl()}, {19'd0, exp_ctl(4'd0, 1'b0)});
    exp_cnt = '0;
    @(negedge clk);
    chk("hold_state", {28'd0, state}, 32'd0);
    reset = 1'b0;

    // Retire R-types until the 4-bit counter wraps back to zero
    do begin
      run_instr("wrap_r", 7'b0110011, 1'b0, 4, 24'h007610, 2'b00, 1'b0);
    end while (exp_cnt != '0);
    chk("wrap_zero", {28'd0, instret}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
